// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the data-memory access unit: access-size and
//   load-extension codes, the FSM state encoding, the captured-request
//   struct and the access legality check.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;
  localparam logic [1:0] MEM_SIZE_ILL  = 2'b11;

  localparam logic MEM_EXT_SIGN = 1'b0;
  localparam logic MEM_EXT_ZERO = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_DONE   = 3'd5
  } memState_t;

  // Access attributes latched when the request is accepted in IDLE.
  typedef struct packed {
    logic [1:0]  size;
    logic        ext;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } memReq_t;

  // An access is rejected without touching memory when it is misaligned
  // for its size, uses the reserved size code, or asks for read and write.
  function automatic logic accessFault(input logic rd, input logic wr,
                                       input logic [1:0] size,
                                       input logic [1:0] lane);
    accessFault = (rd & wr)
                | (size == MEM_SIZE_ILL)
                | ((size == MEM_SIZE_WORD) & (lane != 2'b00))
                | ((size == MEM_SIZE_HALF) & lane[0]);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Combinational little-endian lane handling for the memory access unit.
//   Ports:
//     lane, size, ext   byte lane (addr[1:0]), access size code, load extension
//     memWord           word read from memory
//     storeData         store data; low byte/half is the payload for SB/SH
//     loadData          selected lane, sign/zero extended to 32 bits
//     mergedWord        memWord with the store payload written into its lane
//     laneData          store payload replicated across all lanes
//     laneMask          byte-enable mask of the lanes the access covers
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        ext,
  input  logic [31:0] memWord,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord,
  output logic [31:0] laneData,
  output logic [3:0]  laneMask
);

  logic [7:0]  bSel;
  logic [15:0] hSel;

  always_comb begin
    bSel       = memWord[{lane, 3'b000} +: 8];
    hSel       = lane[1] ? memWord[31:16] : memWord[15:0];
    loadData   = memWord;
    mergedWord = memWord;
    laneData   = storeData;
    laneMask   = 4'b1111;
    case (size)
      MEM_SIZE_HALF: begin
        loadData = {{16{hSel[15] & (ext == MEM_EXT_SIGN)}}, hSel};
        if (lane[1]) mergedWord[31:16] = storeData[15:0];
        else         mergedWord[15:0]  = storeData[15:0];
        laneData = {2{storeData[15:0]}};
        laneMask = lane[1] ? 4'b1100 : 4'b0011;
      end
      MEM_SIZE_BYTE: begin
        loadData = {{24{bSel[7] & (ext == MEM_EXT_SIGN)}}, bSel};
        mergedWord[{lane, 3'b000} +: 8] = storeData[7:0];
        laneData = {4{storeData[7:0]}};
        laneMask = 4'b0001 << lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Data-memory stage: performs word/half/byte loads (sign or zero extended)
//   and stores against a word-wide memory over a req/ack handshake, stalling
//   the CPU until the access completes. Partial stores are read-modify-write.
//   Build option BYTE_ENABLE_EN: adds mem_be[3:0]; partial stores become a
//   single masked write with the payload replicated across lanes.
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     memRead, memWrite           access request from the control unit
//     memDataSize, memBitExt      00 word/01 half/10 byte; 0 sign/1 zero ext
//     addr, wdata                 byte address, store data
//     rdata, stall, done, mem_err load result, CPU stall, completion pulse, error
//     mem_req, mem_we, mem_addr,
//     mem_wdata, (mem_be)         registered memory request
//     mem_ack, mem_rdata          memory completion and read data
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        memDataSize,
  input  logic              memBitExt,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              mem_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
`ifdef BYTE_ENABLE_EN
  output logic [3:0]        mem_be,
`endif
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  // Last cycle of waiting: the request has then been up TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  memState_t         stateQ, stateD;
  memReq_t           reqQ, reqD;
  logic [7:0]        cntQ, cntD;
  logic [31:0]       rdataD, wdataD;
  logic [ADDR_W-1:0] addrD;
  logic              reqOutD, weD, errQ, errD;
  logic              busReq;
`ifdef BYTE_ENABLE_EN
  logic [3:0]        beD;
`endif

  logic [1:0]  alnLane, alnSize;
  logic [31:0] alnData, loadData, mergedWord, laneData;
  logic [3:0]  laneMask;
  logic        unusedBits;

  assign busReq  = memRead | memWrite;
  assign done    = (stateQ == ST_DONE);
  assign mem_err = errQ;
  assign stall   = busReq & ~done;

  // In IDLE the aligner sees the live request so a byte-enabled partial
  // store can launch with its lanes already replicated; afterwards it works
  // on the captured request.
  assign alnLane = (stateQ == ST_IDLE) ? addr[1:0]   : reqQ.lane;
  assign alnSize = (stateQ == ST_IDLE) ? memDataSize : reqQ.size;
  assign alnData = (stateQ == ST_IDLE) ? wdata       : reqQ.wdata;

  mem_lane_align uAlign (
    .lane       (alnLane),
    .size       (alnSize),
    .ext        (reqQ.ext),
    .memWord    (mem_rdata),
    .storeData  (alnData),
    .loadData   (loadData),
    .mergedWord (mergedWord),
    .laneData   (laneData),
    .laneMask   (laneMask)
  );

`ifdef BYTE_ENABLE_EN
  assign unusedBits = ^{addr[31:ADDR_W+2], mergedWord};
`else
  assign unusedBits = ^{addr[31:ADDR_W+2], laneMask};
`endif

  always_comb begin
    stateD  = stateQ;
    reqD    = reqQ;
    cntD    = cntQ;
    rdataD  = rdata;
    wdataD  = mem_wdata;
    addrD   = mem_addr;
    reqOutD = mem_req;
    weD     = mem_we;
    errD    = errQ;
`ifdef BYTE_ENABLE_EN
    beD     = mem_be;
`endif
    case (stateQ)
      ST_IDLE: begin
        if (busReq) begin
          reqD.size  = memDataSize;
          reqD.ext   = memBitExt;
          reqD.lane  = addr[1:0];
          reqD.wdata = wdata;
          addrD      = addr[ADDR_W+1:2];
          if (accessFault(memRead, memWrite, memDataSize, addr[1:0])) begin
            stateD = ST_DONE;
            errD   = 1'b1;
            rdataD = '0;
          end else begin
            reqOutD = 1'b1;
            cntD    = '0;
            if (memRead) begin
              stateD = ST_RD;
              weD    = 1'b0;
            end else if (memDataSize == MEM_SIZE_WORD) begin
              stateD = ST_WR;
              weD    = 1'b1;
              wdataD = laneData;
`ifdef BYTE_ENABLE_EN
              beD    = laneMask;
`endif
            end else begin
`ifdef BYTE_ENABLE_EN
              stateD = ST_WR;
              weD    = 1'b1;
              wdataD = laneData;
              beD    = laneMask;
`else
              stateD = ST_RMW_RD;
              weD    = 1'b0;
`endif
            end
          end
        end
      end
      ST_RD, ST_WR, ST_RMW_RD, ST_RMW_WR: begin
        if (mem_ack) begin
          cntD = '0;
          case (stateQ)
            ST_RD: begin
              rdataD  = loadData;
              reqOutD = 1'b0;
              stateD  = ST_DONE;
            end
`ifndef BYTE_ENABLE_EN
            // Request stays up; it becomes the write half of the RMW.
            ST_RMW_RD: begin
              wdataD = mergedWord;
              weD    = 1'b1;
              stateD = ST_RMW_WR;
            end
`endif
            default: begin
              reqOutD = 1'b0;
              weD     = 1'b0;
              stateD  = ST_DONE;
            end
          endcase
        end else if (cntQ == CNT_LAST) begin
          // Abandon the access; an unfinished RMW never issued its write.
          reqOutD = 1'b0;
          weD     = 1'b0;
          errD    = 1'b1;
          rdataD  = '0;
          stateD  = ST_DONE;
        end else begin
          cntD = cntQ + 8'd1;
        end
      end
      ST_DONE: begin
        errD   = 1'b0;
        stateD = ST_IDLE;
      end
      default: begin
        stateD  = ST_IDLE;
        reqOutD = 1'b0;
        weD     = 1'b0;
        errD    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= ST_IDLE;
      reqQ      <= '0;
      cntQ      <= '0;
      rdata     <= '0;
      mem_wdata <= '0;
      mem_addr  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      errQ      <= 1'b0;
`ifdef BYTE_ENABLE_EN
      mem_be    <= '0;
`endif
    end else begin
      stateQ    <= stateD;
      reqQ      <= reqD;
      cntQ      <= cntD;
      rdata     <= rdataD;
      mem_wdata <= wdataD;
      mem_addr  <= addrD;
      mem_req   <= reqOutD;
      mem_we    <= weD;
      errQ      <= errD;
`ifdef BYTE_ENABLE_EN
      mem_be    <= beD;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 255;
`ifdef BYTE_ENABLE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memRead = 0, memWrite = 0, memBitExt = 0;
  logic [1:0]  memDataSize = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] rdata;
  logic        stall, done, mem_err, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef BYTE_ENABLE_EN
  logic [3:0]  mem_be;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .memDataSize(memDataSize), .memBitExt(memBitExt), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .done(done), .mem_err(mem_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef BYTE_ENABLE_EN
    .mem_be(mem_be),
`endif
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // devMem is the memory device driven by the DUT's bus; refMem is the
  // expected architectural memory image.
  logic [31:0] devMem [0:1023];
  logic [31:0] refMem [0:1023];
  int vecCnt = 0, missCnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCnt++;
    if (got !== exp) begin
      missCnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nBytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [1:0] sz,
                                          input logic ext, input logic [1:0] lane);
    logic [31:0] v;
    int sh;
    sh = 8 * int'(lane);
    if (sz == 2'b00) return w;
    if (sz == 2'b01) begin
      v = (w >> sh) & 32'hFFFF;
      if (!ext && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = (w >> sh) & 32'hFF;
      if (!ext && v >= 32'h80) v = v + 32'hFFFFFF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] refStore(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] m;
    int sh;
    m  = (sz == 2'b10) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFFFFFF;
    sh = 8 * int'(lane);
    return (old & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  // One CPU access. dly = wait cycles before each ack; ackPhases = how many
  // memory phases get acked at all (fewer than needed forces a timeout).
  task automatic doAccess(input string tag, input logic rd, input logic wr,
                          input logic [1:0] sz, input logic ext, input logic [31:0] a,
                          input logic [31:0] wd, input int dly, input int ackPhases);
    logic fault, partial, toErr, ackPrev, fin;
    logic [9:0] wa;
    logic [1:0] lane;
    logic [31:0] expRd, beExp;
    int nb, phases, acked, expStall, stallN, reqN, ph, waitN;
    wa      = a[11:2];
    lane    = a[1:0];
    nb      = nBytes(sz);
    fault   = (sz == 2'b11) || (rd && wr) || ((a % nb) != 0);
    partial = wr && (sz != 2'b00);
    phases  = fault ? 0 : (partial && !BE_EN) ? 2 : 1;
    acked   = (ackPhases < phases) ? ackPhases : phases;
    toErr   = (acked < phases);
    expStall = 1 + acked * (dly + 1) + (toErr ? TIMEOUT : 0);
    expRd   = (fault || toErr) ? 32'h0 : refLoad(refMem[wa], sz, ext, lane);
    beExp   = ((32'h1 << nb) - 1) << lane;
    if (wr && !fault && !toErr) refMem[wa] = refStore(refMem[wa], wd, sz, lane);

    memRead = rd; memWrite = wr; memDataSize = sz; memBitExt = ext; addr = a; wdata = wd;
    stallN = 0; reqN = 0; ph = 0; waitN = 0; ackPrev = 0; fin = 0;
    for (int cyc = 0; cyc < expStall + 20 && !fin; cyc++) begin
      #1;
      if (done) fin = 1;
      else begin
        stallN += int'(stall);
        if (mem_req) begin
          reqN++;
          if (ackPrev) begin ph++; waitN = 0; end
          ackPrev = 0;
          if (ph < ackPhases && waitN == dly) begin
            chk({tag, "_addr"}, 32'(mem_addr), 32'(wa));
            chk({tag, "_we"}, 32'(mem_we), (rd || (partial && !BE_EN && ph == 0)) ? 32'h0 : 32'h1);
            mem_ack = 1'b1;
            if (!mem_we) mem_rdata = devMem[mem_addr];
            else begin
`ifdef BYTE_ENABLE_EN
              chk({tag, "_be"}, 32'(mem_be), beExp);
              for (int i = 0; i < 4; i++)
                if (mem_be[i]) devMem[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
`else
              devMem[mem_addr] = mem_wdata;
`endif
            end
            ackPrev = 1;
          end else begin
            mem_ack = 1'b0;
            waitN++;
          end
        end else begin
          mem_ack = 1'b0;
          ackPrev = 0;
        end
        @(posedge clk); #1;
      end
    end
    mem_ack = 1'b0;
    chk({tag, "_done"}, 32'(fin), 32'h1);
    chk({tag, "_stall"}, 32'(stallN), 32'(expStall));
    chk({tag, "_reqcyc"}, 32'(reqN), 32'(expStall - 1));
    chk({tag, "_err"}, 32'(mem_err), 32'(fault || toErr));
    if (rd || fault || toErr) chk({tag, "_rdata"}, rdata, expRd);
    if (wr) chk({tag, "_mem"}, devMem[wa], refMem[wa]);
    @(posedge clk); #1;
    memRead = 0; memWrite = 0;
    #1;
    chk({tag, "_pulse"}, 32'(done), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  sz;
    logic        rd, wr;
    int k;
    for (int i = 0; i < 1024; i++) begin
      devMem[i] = $urandom;
      refMem[i] = devMem[i];
    end
    devMem[2] = 32'h11223344; refMem[2] = 32'h11223344;
    devMem[1] = 32'h80FF0000; refMem[1] = 32'h80FF0000;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    doAccess("lw",  1, 0, 2'b00, 0, 32'h8, 32'h0, 0, 2);
    chk("lw_const", rdata, 32'h11223344);
    doAccess("lb",  1, 0, 2'b10, 0, 32'h7, 32'h0, 0, 2);
    chk("lb_const", rdata, 32'hFFFFFF80);
    doAccess("lbu", 1, 0, 2'b10, 1, 32'h7, 32'h0, 0, 2);
    chk("lbu_const", rdata, 32'h00000080);
    doAccess("lh",  1, 0, 2'b01, 0, 32'h6, 32'h0, 0, 2);
    chk("lh_const", rdata, 32'hFFFF80FF);

    devMem[1] = 32'h11223344; refMem[1] = 32'h11223344;
    doAccess("sb",  0, 1, 2'b10, 0, 32'h5, 32'h000000AB, 0, 2);
    chk("sb_const", devMem[1], 32'h1122AB44);

    doAccess("e_lw",  1, 0, 2'b00, 0, 32'h6, 32'h0, 0, 2);
    doAccess("e_lh",  1, 0, 2'b01, 0, 32'h3, 32'h0, 0, 2);
    doAccess("e_sz",  1, 0, 2'b11, 0, 32'h0, 32'h0, 0, 2);
    doAccess("e_rw",  1, 1, 2'b00, 0, 32'h8, 32'h12345678, 0, 2);

    doAccess("late", 1, 0, 2'b00, 0, 32'h8, 32'h0, 3, 2);
    doAccess("to_ld", 1, 0, 2'b00, 0, 32'hC, 32'h0, 0, 0);
`ifndef BYTE_ENABLE_EN
    doAccess("to_rmw", 0, 1, 2'b01, 0, 32'h22, 32'hBEEF, 1, 1);
`endif
    doAccess("sh_late", 0, 1, 2'b01, 0, 32'h12, 32'hCAFE, 2, 2);

    // Reset in the middle of the write phase of a partial store.
    memWrite = 1; memRead = 0; memDataSize = 2'b10; addr = 32'h15; wdata = 32'h5A;
    @(posedge clk); #1;
    chk("mid_req", 32'(mem_req), 32'h1);
`ifndef BYTE_ENABLE_EN
    mem_ack = 1'b1; mem_rdata = devMem[5];
    @(posedge clk); #1;
    mem_ack = 1'b0;
`endif
    chk("mid_we", 32'(mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'h0);
    chk("mid_rst_we", 32'(mem_we), 32'h0);
    memWrite = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_req", 32'(mem_req), 32'h0);
    chk("stray_done", 32'(done), 32'h0);
    mem_ack = 1'b0;
    @(posedge clk); #1;
    doAccess("post_rst", 1, 0, 2'b00, 0, 32'h14, 32'h0, 0, 2);

    for (int n = 0; n < 120; n++) begin
      a  = ($urandom & 32'hFFFFF000) | ($urandom & 32'h3F);
      wd = $urandom;
      k  = $urandom_range(0, 15);
      sz = (k < 5) ? 2'b00 : (k < 10) ? 2'b01 : (k < 15) ? 2'b10 : 2'b11;
      k  = $urandom_range(0, 19);
      rd = (k < 9) || (k >= 18);
      wr = (k >= 9);
      doAccess("rnd", rd, wr, sz, 1'($urandom_range(0, 1)), a, wd, $urandom_range(0, 3), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
